// File: rtl/dphy_packet_parser.sv
// rtl/dphy_packet_parser.sv - CSI-2 packet header decode and payload forwarding for a single-lane D-PHY byte stream
// Optional header ECC check is enabled by defining DPHY_PKT_ECC_CHECK_EN.
module dphy_packet_parser #(
    parameter logic [7:0]  SYNC_BYTE = 8'hB8,
    parameter logic [15:0] WC_MAX    = 16'd4096
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  byte_i,
    input  logic        valid_i,
    output logic        sync_reset_o,
    output logic        hdr_valid_o,
    output logic [1:0]  vc_o,
    output logic [5:0]  dt_o,
    output logic [15:0] wc_o,
    output logic [7:0]  payload_o,
    output logic        payload_valid_o,
    output logic        payload_last_o,
    output logic        pkt_done_o,
    output logic        pkt_err_o,
    output logic        ecc_err_o
);
    typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, CRC, DONE, FLUSH} state_t;

    state_t      state;
    logic [15:0] byte_cnt;
    logic [7:0]  di_q;
    logic [15:0] wc_q;
    logic        err_q;
    logic        is_long;
    logic        ecc_bad;

    assign is_long = (di_q[5:0] >= 6'h10);

`ifdef DPHY_PKT_ECC_CHECK_EN
    // Each parity bit covers a fixed subset of the 24 header bits {WC, DI}.
    function automatic logic [5:0] hdr_ecc(input logic [23:0] d);
        logic [5:0] p;
        p[0] = ^(d & 24'hF12CB7);
        p[1] = ^(d & 24'hF2555B);
        p[2] = ^(d & 24'h749A6D);
        p[3] = ^(d & 24'hB8E38E);
        p[4] = ^(d & 24'hDF03F0);
        p[5] = ^(d & 24'hEFFC00);
        return p;
    endfunction

    assign ecc_bad = (byte_i[7:6] != 2'b00) || (byte_i[5:0] != hdr_ecc({wc_q, di_q}));
`else
    assign ecc_bad = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state           <= IDLE;
            byte_cnt        <= '0;
            di_q            <= '0;
            wc_q            <= '0;
            err_q           <= 1'b0;
            sync_reset_o    <= 1'b0;
            hdr_valid_o     <= 1'b0;
            vc_o            <= '0;
            dt_o            <= '0;
            wc_o            <= '0;
            payload_o       <= '0;
            payload_valid_o <= 1'b0;
            payload_last_o  <= 1'b0;
            pkt_done_o      <= 1'b0;
            pkt_err_o       <= 1'b0;
            ecc_err_o       <= 1'b0;
        end else begin
            sync_reset_o    <= 1'b0;
            hdr_valid_o     <= 1'b0;
            payload_valid_o <= 1'b0;
            payload_last_o  <= 1'b0;
            pkt_done_o      <= 1'b0;
            pkt_err_o       <= 1'b0;
            ecc_err_o       <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        byte_cnt <= '0;
                        if (byte_i == SYNC_BYTE) begin
                            err_q <= 1'b0;
                            state <= HDR;
                        end else begin
                            err_q     <= 1'b1;
                            pkt_err_o <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                HDR: begin
                    if (!valid_i) begin
                        err_q     <= 1'b1;
                        pkt_err_o <= 1'b1;
                        state     <= DONE;
                    end else begin
                        byte_cnt <= byte_cnt + 16'd1;
                        case (byte_cnt[1:0])
                            2'd0: di_q       <= byte_i;
                            2'd1: wc_q[7:0]  <= byte_i;
                            2'd2: wc_q[15:8] <= byte_i;
                            default: begin
                                // A corrupt header is not trusted for the WC limit check either.
                                if (ecc_bad) begin
                                    err_q     <= 1'b1;
                                    ecc_err_o <= 1'b1;
                                    state     <= DONE;
                                end else if (is_long && (wc_q > WC_MAX)) begin
                                    err_q     <= 1'b1;
                                    pkt_err_o <= 1'b1;
                                    state     <= DONE;
                                end else begin
                                    hdr_valid_o <= 1'b1;
                                    vc_o        <= di_q[7:6];
                                    dt_o        <= di_q[5:0];
                                    wc_o        <= wc_q;
                                    if (!is_long) begin
                                        state <= DONE;
                                    end else if (wc_q == 16'd0) begin
                                        byte_cnt <= 16'd2;
                                        state    <= CRC;
                                    end else begin
                                        byte_cnt <= wc_q;
                                        state    <= PAYLOAD;
                                    end
                                end
                            end
                        endcase
                    end
                end
                PAYLOAD: begin
                    if (!valid_i) begin
                        err_q     <= 1'b1;
                        pkt_err_o <= 1'b1;
                        state     <= DONE;
                    end else begin
                        payload_o       <= byte_i;
                        payload_valid_o <= 1'b1;
                        byte_cnt        <= byte_cnt - 16'd1;
                        if (byte_cnt == 16'd1) begin
                            payload_last_o <= 1'b1;
                            byte_cnt       <= 16'd2;
                            state          <= CRC;
                        end
                    end
                end
                CRC: begin
                    if (!valid_i) begin
                        err_q     <= 1'b1;
                        pkt_err_o <= 1'b1;
                        state     <= DONE;
                    end else begin
                        byte_cnt <= byte_cnt - 16'd1;
                        if (byte_cnt == 16'd1) state <= DONE;
                    end
                end
                DONE: begin
                    sync_reset_o <= 1'b1;
                    pkt_done_o   <= !err_q;
                    byte_cnt     <= '0;
                    // valid_i already low here: FLUSH would have nothing to wait for.
                    state        <= valid_i ? FLUSH : IDLE;
                end
                FLUSH: begin
                    if (!valid_i) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dphy_packet_parser.sv
// tb/tb_dphy_packet_parser.sv - self-checking bench for dphy_packet_parser
// Randomised and directed packets checked cycle by cycle against a packet-level model.
module tb_dphy_packet_parser;
    typedef logic [7:0] bq_t[$];

    localparam int NMAX = 128;
    localparam logic [5:0] ECC_COL [24] = '{
        6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
        6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
        6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [7:0]  byte_i;
    logic        valid_i;
    logic        sync_reset_o, hdr_valid_o;
    logic [1:0]  vc_o;
    logic [5:0]  dt_o;
    logic [15:0] wc_o;
    logic [7:0]  payload_o;
    logic        payload_valid_o, payload_last_o, pkt_done_o, pkt_err_o, ecc_err_o;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0]  s_byte[$];
    logic        s_valid[$];
    logic        e_sync[NMAX], e_hdr[NMAX], e_pv[NMAX], e_last[NMAX];
    logic        e_done[NMAX], e_err[NMAX], e_ecc[NMAX];
    logic [1:0]  e_vc[NMAX];
    logic [5:0]  e_dt[NMAX];
    logic [15:0] e_wc[NMAX];
    logic [7:0]  e_pay[NMAX];

    dphy_packet_parser dut (
        .clk_i(clk_i), .rst_i(rst_i), .byte_i(byte_i), .valid_i(valid_i),
        .sync_reset_o(sync_reset_o), .hdr_valid_o(hdr_valid_o),
        .vc_o(vc_o), .dt_o(dt_o), .wc_o(wc_o),
        .payload_o(payload_o), .payload_valid_o(payload_valid_o),
        .payload_last_o(payload_last_o), .pkt_done_o(pkt_done_o),
        .pkt_err_o(pkt_err_o), .ecc_err_o(ecc_err_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [5:0] ecc6(input logic [23:0] d);
        logic [5:0] p = '0;
        for (int k = 0; k < 24; k++) if (d[k]) p ^= ECC_COL[k];
        return p;
    endfunction

    function automatic bq_t make_pkt(input logic [7:0] di, input logic [15:0] wc, input bit flip);
        bq_t p;
        logic [7:0] e;
        e = {2'b00, ecc6({wc, di})};
        if (flip) e ^= 8'(8'h01 << $urandom_range(0, 7));
        p = '{8'hB8, di, wc[7:0], wc[15:8], e};
        if (di[5:0] >= 6'h10 && wc <= 16'd64) begin
            for (int i = 0; i < int'(wc) + 2; i++) p.push_back(8'($urandom));
        end
        return p;
    endfunction

    task automatic clear_exp();
        for (int i = 0; i < NMAX; i++) begin
            e_sync[i] = 0; e_hdr[i] = 0; e_pv[i] = 0; e_last[i] = 0;
            e_done[i] = 0; e_err[i] = 0; e_ecc[i] = 0;
            e_vc[i] = 0; e_dt[i] = 0; e_wc[i] = 0; e_pay[i] = 0;
        end
    endtask

    // Packet-level reference: stream position n is the first cycle with valid_i low.
    task automatic model_pkt(input bq_t p, input int n, input int o);
        logic [7:0]  di;
        logic [15:0] wc;
        bit          long_pkt, ecc_ok;
        int          need;
        if (p[0] != 8'hB8) begin e_err[o] = 1; e_sync[o + 1] = 1; return; end
        if (n < 5) begin e_err[o + n] = 1; e_sync[o + n + 1] = 1; return; end
        di = p[1];
        wc = {p[3], p[2]};
        long_pkt = (di[5:0] >= 6'h10);
`ifdef DPHY_PKT_ECC_CHECK_EN
        ecc_ok = (p[4] == {2'b00, ecc6({wc, di})});
`else
        ecc_ok = 1'b1;
`endif
        if (!ecc_ok) begin e_ecc[o + 4] = 1; e_sync[o + 5] = 1; return; end
        if (long_pkt && wc > 16'd4096) begin e_err[o + 4] = 1; e_sync[o + 5] = 1; return; end
        e_hdr[o + 4] = 1; e_vc[o + 4] = di[7:6]; e_dt[o + 4] = di[5:0]; e_wc[o + 4] = wc;
        if (!long_pkt) begin e_done[o + 5] = 1; e_sync[o + 5] = 1; return; end
        for (int i = 0; i < int'(wc) && 5 + i < n; i++) begin
            e_pv[o + 5 + i] = 1;
            e_pay[o + 5 + i] = s_byte[o + 5 + i];
            e_last[o + 5 + i] = (i == int'(wc) - 1);
        end
        need = 5 + int'(wc) + 2;
        if (n < need) begin e_err[o + n] = 1; e_sync[o + n + 1] = 1; end
        else begin e_done[o + need] = 1; e_sync[o + need] = 1; end
    endtask

    task automatic add_pkt(input bq_t p, input int n);
        int o = s_byte.size();
        for (int i = 0; i < n; i++) begin
            s_byte.push_back(i < p.size() ? p[i] : 8'($urandom));
            s_valid.push_back(1'b1);
        end
        model_pkt(p, n, o);
    endtask

    task automatic add_idle(input int k);
        for (int i = 0; i < k; i++) begin
            s_byte.push_back(8'($urandom));
            s_valid.push_back(1'b0);
        end
    endtask

    task automatic run_stream(input string tag);
        logic [38:0] obs, expv;
        int total = s_byte.size() + 2;
        for (int c = 0; c < total; c++) begin
            valid_i = (c < s_byte.size()) ? s_valid[c] : 1'b0;
            byte_i  = (c < s_byte.size()) ? s_byte[c] : 8'h00;
            @(posedge clk_i);
            #1;
            obs = {sync_reset_o, hdr_valid_o, payload_valid_o, payload_last_o, pkt_done_o,
                   pkt_err_o, ecc_err_o, e_hdr[c] ? {vc_o, dt_o, wc_o} : 24'd0,
                   e_pv[c] ? payload_o : 8'd0};
            expv = {e_sync[c], e_hdr[c], e_pv[c], e_last[c], e_done[c], e_err[c], e_ecc[c],
                    e_vc[c], e_dt[c], e_wc[c], e_pay[c]};
            tests_run++;
            assert (obs === expv) else begin
                tests_failed++;
                $error("FAIL %s cycle %0d observed %h expected %h", tag, c, obs, expv);
            end
        end
        valid_i = 1'b0;
        s_byte.delete();
        s_valid.delete();
        clear_exp();
    endtask

    task automatic check_all_zero(input string tag);
        logic [38:0] obs;
        obs = {sync_reset_o, hdr_valid_o, payload_valid_o, payload_last_o, pkt_done_o,
               pkt_err_o, ecc_err_o, vc_o, dt_o, wc_o, payload_o};
        tests_run++;
        assert (obs === 39'd0) else begin
            tests_failed++;
            $error("FAIL %s observed %h expected 0", tag, obs);
        end
    endtask

    initial begin
        bq_t p, q;
        rst_i = 1'b1; valid_i = 1'b0; byte_i = 8'h00;
        clear_exp();
        repeat (3) @(posedge clk_i);
        #1;
        check_all_zero("reset");
        rst_i = 1'b0;

        p = make_pkt(8'h00, 16'h3412, 0);
        add_pkt(p, p.size()); add_idle(2); run_stream("short");

        p = make_pkt(8'h2A, 16'd4, 0);
        p[5] = 8'h11; p[6] = 8'h22; p[7] = 8'h33; p[8] = 8'h44; p[9] = 8'hC0; p[10] = 8'hC1;
        add_pkt(p, p.size()); add_idle(2); run_stream("long4");

        p = make_pkt(8'h2A, 16'd4, 0);
        p[0] = 8'hB9;
        add_pkt(p, p.size()); add_idle(2); run_stream("bad_sync");

        p = make_pkt(8'h2B, 16'd8, 0);
        add_pkt(p, 8); add_idle(2); run_stream("drop_payload");

        p = make_pkt(8'h2A, 16'h2000, 0);
        add_pkt(p, 5); add_idle(2); run_stream("wc_too_big");

        p = make_pkt(8'h2A, 16'd4097, 0);
        add_pkt(p, 5); add_idle(2); run_stream("wc_max_plus1");

        p = make_pkt(8'h2A, 16'd4096, 0);
        add_pkt(p, 9); add_idle(2); run_stream("wc_max_trunc");

        p = make_pkt(8'h24, 16'd0, 0);
        add_pkt(p, p.size()); add_idle(2); run_stream("long_wc0");

        p = make_pkt(8'h05, 16'hBEEF, 1);
        add_pkt(p, p.size()); add_idle(2); run_stream("ecc_flip");

        p = make_pkt(8'h6A, 16'd3, 0);
        q = make_pkt(8'hC1, 16'h0101, 0);
        add_pkt(p, p.size()); add_idle(1); add_pkt(q, q.size());
        add_idle(1); add_pkt(p, p.size()); add_idle(2);
        run_stream("back_to_back");

        p = make_pkt(8'h2B, 16'd8, 0);
        for (int i = 0; i < 7; i++) begin
            byte_i = p[i]; valid_i = 1'b1;
            @(posedge clk_i);
            #1;
        end
        tests_run++;
        assert (payload_valid_o === 1'b1 && payload_o === p[6]) else begin
            tests_failed++;
            $error("FAIL pre_reset_payload observed %b/%h expected 1/%h", payload_valid_o, payload_o, p[6]);
        end
        rst_i = 1'b1; byte_i = p[7];
        @(posedge clk_i);
        #1;
        check_all_zero("mid_payload_reset");
        rst_i = 1'b0; valid_i = 1'b0;
        @(posedge clk_i);
        #1;
        check_all_zero("post_reset_idle");
        p = make_pkt(8'h12, 16'h00A5, 0);
        add_pkt(p, p.size()); add_idle(2); run_stream("after_reset");

        for (int t = 0; t < 40; t++) begin
            logic [7:0]  di;
            logic [15:0] wc;
            int          r, n;
            bit          is_long;
            r = $urandom_range(0, 99);
            di = 8'($urandom);
            is_long = (di[5:0] >= 6'h10);
            wc = is_long ? 16'($urandom_range(0, 16)) : 16'($urandom);
            if (r < 8) wc = 16'd4097;
            else if (r < 14) wc = 16'd4096;
            p = make_pkt(di, wc, $urandom_range(0, 9) == 0);
            n = p.size();
            if (r >= 8 && r < 14 && is_long) n = 5 + $urandom_range(0, 5);
            else if ($urandom_range(0, 6) == 0) n = $urandom_range(1, p.size() - 1);
            if ($urandom_range(0, 11) == 0) p[0] = p[0] ^ 8'(8'h01 << $urandom_range(0, 7));
            add_pkt(p, n); add_idle(2);
            run_stream($sformatf("rand%0d", t));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
